// File: rtl/breakout_game_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : breakout_game_ctrl_if
// Description : Bundles the game-event inputs and the game-status outputs of
//               breakout_game_ctrl.
//               master : game logic / video side (drives the events)
//               slave  : breakout_game_ctrl (drives the status)
// Signals     : frame_tick, start, pause, hit, miss, bricks_clear (events)
//               state[1:0], score/hiscore[4*DIGITS-1:0] (BCD),
//               lives[LIFE_W-1:0], gra_still, ball_reset, game_over, win
// Revision    : 1.0 - initial release
// ============================================================================
interface breakout_game_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int LIFE_W = 2
);
    logic                  frame_tick;
    logic                  start;
    logic                  pause;
    logic                  hit;
    logic                  miss;
    logic                  bricks_clear;
    logic [1:0]            state;
    logic [4*DIGITS-1:0]   score;
    logic [4*DIGITS-1:0]   hiscore;
    logic [LIFE_W-1:0]     lives;
    logic                  gra_still;
    logic                  ball_reset;
    logic                  game_over;
    logic                  win;

    modport master (
        output frame_tick, start, pause, hit, miss, bricks_clear,
        input  state, score, hiscore, lives, gra_still, ball_reset,
               game_over, win
    );

    modport slave (
        input  frame_tick, start, pause, hit, miss, bricks_clear,
        output state, score, hiscore, lives, gra_still, ball_reset,
               game_over, win
    );
endinterface
`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : breakout_game_ctrl
// Description : Game-flow controller for a Breakout-style game. Sequences
//               IDLE -> SERVE -> PLAY -> OVER, keeps a saturating BCD score,
//               a best-score register, a lives counter and a frame-based
//               wait counter for the serve delay and the game-over hold-off.
// Ports       : clk   - system clock
//               reset - synchronous active-high reset
//               bus   - breakout_game_ctrl_if.slave (events in, status out)
// Revision    : 1.0 - initial release
// ============================================================================
module breakout_game_ctrl #(
    parameter int DIGITS      = 4,
    parameter int LIVES       = 3,
    parameter int LIFE_W      = 2,
    parameter int WAIT_FRAMES = 120,
    parameter int FRAME_W     = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    breakout_game_ctrl_if.slave    bus
);

    localparam int SW = 4 * DIGITS;
    localparam logic [FRAME_W-1:0] c_wait_max  = FRAME_W'(WAIT_FRAMES);
    localparam logic [FRAME_W-1:0] c_wait_last = FRAME_W'(WAIT_FRAMES - 1);
    localparam logic [LIFE_W-1:0]  c_lives     = LIFE_W'(LIVES);
    localparam logic [LIFE_W-1:0]  c_life_one  = LIFE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SW-1:0]       r_score, w_score_nxt;
    logic [SW-1:0]       r_hiscore, w_hiscore_nxt;
    logic [LIFE_W-1:0]   r_lives, w_lives_nxt;
    logic [FRAME_W-1:0]  r_wait, w_wait_nxt;
    logic                r_win, w_win_nxt;
    logic                r_pause;
    logic [SW-1:0]       w_score_hit;

    // BCD +1 with ripple carry. A carry out of the top digit means every digit
    // was 9, in which case the score saturates at its old value.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        if (carry) begin
            r = v;
        end
        return r;
    endfunction

    assign w_score_hit = bus.hit ? bcd_inc(r_score) : r_score;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_score   <= '0;
            r_hiscore <= '0;
            r_lives   <= '0;
            r_wait    <= '0;
            r_win     <= 1'b0;
            r_pause   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_score   <= w_score_nxt;
            r_hiscore <= w_hiscore_nxt;
            r_lives   <= w_lives_nxt;
            r_wait    <= w_wait_nxt;
            r_win     <= w_win_nxt;
            r_pause   <= bus.pause;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_score_nxt   = r_score;
        w_hiscore_nxt = r_hiscore;
        w_lives_nxt   = r_lives;
        w_wait_nxt    = r_wait;
        w_win_nxt     = r_win;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_SERVE;
                    w_score_nxt = '0;
                    w_lives_nxt = c_lives;
                    w_wait_nxt  = '0;
                    w_win_nxt   = 1'b0;
                end
            end

            S_SERVE: begin
                if (bus.frame_tick) begin
                    if (r_wait == c_wait_last) begin
                        w_state_nxt = S_PLAY;
                        w_wait_nxt  = '0;
                    end else begin
                        w_wait_nxt  = r_wait + 1'b1;
                    end
                end
            end

            S_PLAY: begin
                if (!bus.pause) begin
                    // The hit of this cycle counts even when the game ends now.
                    w_score_nxt = w_score_hit;
                    if (bus.bricks_clear) begin
                        w_state_nxt = S_OVER;
                        w_win_nxt   = 1'b1;
                        w_wait_nxt  = '0;
                    end else if (bus.miss) begin
                        w_wait_nxt  = '0;
                        w_lives_nxt = r_lives - 1'b1;
                        if (r_lives == c_life_one) begin
                            w_state_nxt = S_OVER;
                            w_win_nxt   = 1'b0;
                        end else begin
                            w_state_nxt = S_SERVE;
                        end
                    end
                end
            end

            S_OVER: begin
                if (bus.start && (r_wait == c_wait_max)) begin
                    w_state_nxt = S_SERVE;
                    w_score_nxt = '0;
                    w_lives_nxt = c_lives;
                    w_wait_nxt  = '0;
                    w_win_nxt   = 1'b0;
                end else if (bus.frame_tick && (r_wait != c_wait_max)) begin
                    w_wait_nxt  = r_wait + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Best score is captured once, on the transition into OVER.
        if ((r_state != S_OVER) && (w_state_nxt == S_OVER) &&
            (w_score_nxt > r_hiscore)) begin
            w_hiscore_nxt = w_score_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state only (pause is registered)
    // ------------------------------------------------------------------
    assign bus.state      = r_state;
    assign bus.score      = r_score;
    assign bus.hiscore    = r_hiscore;
    assign bus.lives      = r_lives;
    assign bus.win        = r_win;
    assign bus.game_over  = (r_state == S_OVER);
    assign bus.ball_reset = (r_state == S_IDLE) || (r_state == S_SERVE);
    assign bus.gra_still  = (r_state != S_PLAY) || r_pause;

endmodule
`default_nettype wire

// File: tb/tb_breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_breakout_game_ctrl
// Description : Directed testbench for breakout_game_ctrl. Instance A uses the
//               default parameters; instance B uses DIGITS=2 and a short
//               serve delay for the score-saturation case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_breakout_game_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    breakout_game_ctrl_if #(.DIGITS(4), .LIFE_W(2)) bus_a ();
    breakout_game_ctrl_if #(.DIGITS(2), .LIFE_W(2)) bus_b ();

    breakout_game_ctrl #(
        .DIGITS(4), .LIVES(3), .LIFE_W(2), .WAIT_FRAMES(120), .FRAME_W(8)
    ) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    breakout_game_ctrl #(
        .DIGITS(2), .LIVES(3), .LIFE_W(2), .WAIT_FRAMES(2), .FRAME_W(2)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks_a(input int n);
        bus_a.frame_tick = 1'b1;
        repeat (n) cyc();
        bus_a.frame_tick = 1'b0;
    endtask

    task automatic hits_a(input int n);
        bus_a.hit = 1'b1;
        repeat (n) cyc();
        bus_a.hit = 1'b0;
    endtask

    task automatic serve_a();
        ticks_a(119);
        chk("serve_t119_state", 32'(bus_a.state), 32'd1);
        chk("serve_t119_ballrst", 32'(bus_a.ball_reset), 32'd1);
        ticks_a(1);
        chk("serve_t120_state", 32'(bus_a.state), 32'd2);
        chk("serve_t120_ballrst", 32'(bus_a.ball_reset), 32'd0);
        chk("serve_t120_still", 32'(bus_a.gra_still), 32'd0);
    endtask

    task automatic miss_a();
        bus_a.miss = 1'b1;
        cyc();
        bus_a.miss = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        {bus_a.frame_tick, bus_a.start, bus_a.pause, bus_a.hit, bus_a.miss,
         bus_a.bricks_clear} = '0;
        {bus_b.frame_tick, bus_b.start, bus_b.pause, bus_b.hit, bus_b.miss,
         bus_b.bricks_clear} = '0;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_state",    32'(bus_a.state),      32'd0);
        chk("rst_score",    32'(bus_a.score),      32'd0);
        chk("rst_hiscore",  32'(bus_a.hiscore),    32'd0);
        chk("rst_lives",    32'(bus_a.lives),      32'd0);
        chk("rst_win",      32'(bus_a.win),        32'd0);
        chk("rst_gameover", 32'(bus_a.game_over),  32'd0);
        chk("rst_still",    32'(bus_a.gra_still),  32'd1);
        chk("rst_ballrst",  32'(bus_a.ball_reset), 32'd1);

        // ---------------- game 1: win via bricks_clear ----------------
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        chk("start_state", 32'(bus_a.state), 32'd1);
        chk("start_lives", 32'(bus_a.lives), 32'd3);
        serve_a();

        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        chk("start_in_play_ignored", 32'(bus_a.state), 32'd2);

        hits_a(7);
        chk("score7", 32'(bus_a.score), 32'h0007);
        {bus_a.hit, bus_a.miss, bus_a.bricks_clear} = 3'b111;
        cyc();
        {bus_a.hit, bus_a.miss, bus_a.bricks_clear} = 3'b000;
        chk("clr_state",    32'(bus_a.state),     32'd3);
        chk("clr_win",      32'(bus_a.win),       32'd1);
        chk("clr_lives",    32'(bus_a.lives),     32'd3);
        chk("clr_score",    32'(bus_a.score),     32'h0008);
        chk("clr_hiscore",  32'(bus_a.hiscore),   32'h0008);
        chk("clr_gameover", 32'(bus_a.game_over), 32'd1);
        chk("clr_still",    32'(bus_a.gra_still), 32'd1);

        // ---------------- OVER hold-off ----------------
        ticks_a(50);
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        chk("over_early_start", 32'(bus_a.state), 32'd3);
        ticks_a(75);    // past the limit: counter must saturate, not wrap
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        chk("restart_state",   32'(bus_a.state),   32'd1);
        chk("restart_score",   32'(bus_a.score),   32'h0000);
        chk("restart_lives",   32'(bus_a.lives),   32'd3);
        chk("restart_hiscore", 32'(bus_a.hiscore), 32'h0008);
        chk("restart_win",     32'(bus_a.win),     32'd0);

        // ---------------- game 2: lose all lives ----------------
        serve_a();
        hits_a(5);
        miss_a();
        chk("miss1_lives", 32'(bus_a.lives), 32'd2);
        chk("miss1_state", 32'(bus_a.state), 32'd1);
        serve_a();
        hits_a(7);
        chk("score12_carry", 32'(bus_a.score), 32'h0012);
        miss_a();
        chk("miss2_lives", 32'(bus_a.lives), 32'd1);
        serve_a();

        bus_a.pause = 1'b1;
        {bus_a.hit, bus_a.miss} = 2'b11;
        cyc();
        {bus_a.hit, bus_a.miss} = 2'b00;
        chk("pause_score", 32'(bus_a.score),     32'h0012);
        chk("pause_lives", 32'(bus_a.lives),     32'd1);
        chk("pause_state", 32'(bus_a.state),     32'd2);
        chk("pause_still", 32'(bus_a.gra_still), 32'd1);
        bus_a.pause = 1'b0;
        cyc();
        chk("unpause_still", 32'(bus_a.gra_still), 32'd0);

        miss_a();
        chk("miss3_lives",    32'(bus_a.lives),     32'd0);
        chk("miss3_state",    32'(bus_a.state),     32'd3);
        chk("miss3_win",      32'(bus_a.win),       32'd0);
        chk("miss3_gameover", 32'(bus_a.game_over), 32'd1);
        chk("miss3_hiscore",  32'(bus_a.hiscore),   32'h0012);

        // ---------------- reset mid-SERVE ----------------
        ticks_a(120);
        bus_a.start = 1'b1;
        cyc();
        bus_a.start = 1'b0;
        chk("serve3_state", 32'(bus_a.state), 32'd1);
        ticks_a(30);
        reset = 1'b1;
        bus_a.start = 1'b1;
        cyc();
        reset = 1'b0;
        bus_a.start = 1'b0;
        chk("midrst_state",   32'(bus_a.state),   32'd0);
        chk("midrst_hiscore", 32'(bus_a.hiscore), 32'h0000);
        chk("midrst_lives",   32'(bus_a.lives),   32'd0);
        chk("midrst_score",   32'(bus_a.score),   32'h0000);

        // ---------------- instance B: DIGITS=2 saturation ----------------
        bus_b.start = 1'b1;
        cyc();
        bus_b.start = 1'b0;
        bus_b.frame_tick = 1'b1;
        repeat (2) cyc();
        bus_b.frame_tick = 1'b0;
        chk("b_play", 32'(bus_b.state), 32'd2);
        bus_b.hit = 1'b1;
        repeat (99) cyc();
        bus_b.hit = 1'b0;
        chk("b_score99", 32'(bus_b.score), 32'h99);
        bus_b.hit = 1'b1;
        repeat (5) cyc();
        bus_b.hit = 1'b0;
        chk("b_score_sat", 32'(bus_b.score), 32'h99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/breakout_game_ctrl.md
BREAKOUT_GAME_CTRL -- requirements
Module: breakout_game_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD score digits (1..8).
REQ-002 SHALL have parameter LIVES, default 3: lives per game (1..2^LIFE_W-1).
REQ-003 SHALL have parameter LIFE_W, default 2: width of lives counter.
REQ-004 SHALL have parameter WAIT_FRAMES, default 120: frame_ticks spent in serve and game-over wait (>=1).
REQ-005 SHALL have parameter FRAME_W, default 8: width of wait counter (2^FRAME_W > WAIT_FRAMES).
REQ-006 SHALL have port clk  input  1  system clock; the only clock.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-009 SHALL have port start  input  1  one-cycle start/restart request.
REQ-010 SHALL have port pause  input  1  level; freeze play.
REQ-011 SHALL have port hit  input  1  one-cycle brick-hit pulse.
REQ-012 SHALL have port miss  input  1  one-cycle ball-lost pulse.
REQ-013 SHALL have port bricks_clear  input  1  one-cycle all-bricks-gone pulse.
REQ-014 SHALL have port state  output  2  IDLE=0, SERVE=1, PLAY=2, OVER=3.
REQ-015 SHALL have port score  output  4*DIGITS  BCD score, digit 0 in [3:0].
REQ-016 SHALL have port hiscore  output  4*DIGITS  BCD best score since reset.
REQ-017 SHALL have port lives  output  LIFE_W  remaining lives.
REQ-018 SHALL have port gra_still  output  1  freeze ball/paddle motion.
REQ-019 SHALL have port ball_reset  output  1  hold ball at serve position.
REQ-020 SHALL have port game_over  output  1  high in OVER.
REQ-021 SHALL have port win  output  1  high in OVER when entered via bricks_clear.

Function
REQ-022 All outputs SHALL be registered or decoded from registered state only; inputs sampled at clk rising edge take effect on the next cycle.
REQ-023 IDLE: gra_still=1, ball_reset=1; start -> SERVE, score cleared, lives=LIVES, wait counter=0.
REQ-024 SERVE: gra_still=1, ball_reset=1; wait counter increments on each frame_tick; on the frame_tick making count equal WAIT_FRAMES -> PLAY, counter cleared.
REQ-025 PLAY, pause=0: gra_still=0, ball_reset=0; hit increments score by 1 in BCD with per-digit carry.
REQ-026 Score SHALL saturate at all digits 9; further hits leave it unchanged.
REQ-027 PLAY miss: lives decrements; if lives was 1 -> OVER with lives=0, win=0; else -> SERVE, counter cleared.
REQ-028 PLAY bricks_clear -> OVER with win=1, lives unchanged.
REQ-029 Simultaneous hit and miss/bricks_clear: score increment SHALL still apply in that cycle.
REQ-030 Simultaneous miss and bricks_clear: bricks_clear wins; lives not decremented.
REQ-031 PLAY, pause=1: gra_still=1; hit, miss, bricks_clear ignored; state held.
REQ-032 pause SHALL have no effect outside PLAY; frame_tick counting in SERVE/OVER continues.
REQ-033 On the cycle entering OVER, hiscore SHALL load the final score (including same-cycle hit) if strictly greater (unsigned compare of BCD vector).
REQ-034 OVER: gra_still=1, game_over=1; wait counter counts frame_ticks up to WAIT_FRAMES and holds; start before count reaches WAIT_FRAMES ignored.
REQ-035 OVER with count reached: start -> SERVE as REQ-023 (score cleared, lives=LIVES, win cleared); hiscore retained.
REQ-036 start SHALL be ignored in SERVE and PLAY; hit/miss/bricks_clear ignored outside PLAY.
REQ-037 Wait counter SHALL never exceed WAIT_FRAMES (no wrap).

Reset
REQ-038 reset=1 at a clk edge SHALL, from any state including mid-SERVE/OVER countdown: state=IDLE, score=0, hiscore=0, lives=0, wait counter=0, win=0, game_over=0, gra_still=1, ball_reset=1.
REQ-039 reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-040 Defaults: reset, start, 120 frame_ticks -> state=2 after 120th tick; before it state=1, ball_reset=1.
REQ-041 DIGITS=2: 99 hits then 5 more -> score=8'h99, no wrap.
REQ-042 LIVES=3: three misses with serves between -> lives 2,1,0; state=3, win=0, game_over=1; score 12 -> hiscore=12.
REQ-043 Same-cycle miss+bricks_clear+hit with score 7 -> state=3, win=1, lives unchanged, score=8, hiscore=8.
REQ-044 pause=1 in PLAY with hit and miss pulses -> score, lives, state unchanged, gra_still=1.
REQ-045 OVER: start at tick 50 ignored; start after tick 120 -> SERVE, score=0, lives=3, hiscore kept; reset mid-SERVE -> IDLE, hiscore=0.
